// File: rtl/trace_capture.sv
// Commit/memory trace buffer: register-write and data-memory events are stamped
// with a free-running timestamp and queued in a first-word-fall-through FIFO.
module trace_capture #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int TS_W      = 16,
    parameter bit FILTER_X0 = 1'b1,
    localparam int ENTRY_W  = 2 + ADDR_W + DATA_W + TS_W,
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic [2:0]         cfg_en,
    input  logic               reg_write_sig,
    input  logic [4:0]         reg_num,
    input  logic [DATA_W-1:0]  reg_data,
    input  logic               wr,
    input  logic               rd,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ENTRY_W-1:0] out_data,
    output logic [LVL_W-1:0]   level,
    output logic [15:0]        drop_cnt,
    output logic               overflow,
    output logic               conflict
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        T_REG  = 2'b01,
        T_MEMW = 2'b10,
        T_MEMR = 2'b11
    } ev_type_e;

    typedef struct packed {
        logic [1:0]        typ;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [TS_W-1:0]  ts;

    logic             both, reg_ev, memw_ev, memr_ev, mem_ev, pop;
    logic [LVL_W-1:0] free;
    logic [1:0]       ok;
    logic [1:0]       n_push, n_drop;
    logic [16:0]      drop_sum;
    entry_t           reg_ent, mem_ent;

    assign both    = wr & rd;
    assign reg_ev  = reg_write_sig & cfg_en[0] & ~(FILTER_X0 & (reg_num == 5'd0));
    assign memw_ev = wr & ~rd & cfg_en[1];
    assign memr_ev = rd & ~wr & cfg_en[2];
    assign mem_ev  = memw_ev | memr_ev;

    // Free space is taken before this cycle's pop, so a pop never makes room
    // for a same-cycle push. Lane 0 (REG) always claims the first free slot.
    assign free  = LVL_W'(DEPTH) - level;
    assign ok[0] = reg_ev & (free != '0);
    assign ok[1] = mem_ev & (reg_ev ? (free >= LVL_W'(2)) : (free != '0));

    assign n_push   = {1'b0, ok[0]} + {1'b0, ok[1]};
    assign n_drop   = {1'b0, reg_ev & ~ok[0]} + {1'b0, mem_ev & ~ok[1]};
    assign drop_sum = {1'b0, drop_cnt} + {15'd0, n_drop};
    assign pop      = out_valid & out_ready;

    assign reg_ent.typ  = T_REG;
    assign reg_ent.idx  = ADDR_W'(reg_num);
    assign reg_ent.data = reg_data;
    assign reg_ent.ts   = ts;

    assign mem_ent.typ  = memw_ev ? T_MEMW : T_MEMR;
    assign mem_ent.idx  = addr;
    assign mem_ent.data = memw_ev ? wr_data : rd_data;
    assign mem_ent.ts   = ts;

    assign out_valid = (level != '0);
    assign out_data  = mem[rptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (ok[0]) mem[wptr] <= reg_ent;
            if (ok[1]) mem[wptr + PTR_W'(ok[0])] <= mem_ent;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            ts       <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
            conflict <= 1'b0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            ts       <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
            conflict <= 1'b0;
        end else begin
            wptr  <= wptr + PTR_W'(n_push);
            rptr  <= rptr + PTR_W'(pop);
            level <= level + LVL_W'(n_push) - LVL_W'(pop);
            ts    <= ts + 1'b1;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (n_drop != 2'd0) overflow <= 1'b1;
            if (both)           conflict <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: directed vector table, FIFO wrap and async reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_trace_capture;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int TS_W    = 8;
    localparam int ENTRY_W = 2 + ADDR_W + DATA_W + TS_W;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic               tb_clk = 1'b0;
    logic               reset, clr, reg_write_sig, wr, rd, out_ready;
    logic [2:0]         cfg_en;
    logic [4:0]         reg_num;
    logic [DATA_W-1:0]  reg_data, wr_data, rd_data;
    logic [ADDR_W-1:0]  addr;
    logic               out_valid, overflow, conflict;
    logic [ENTRY_W-1:0] out_data;
    logic [LVL_W-1:0]   level;
    logic [15:0]        drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 tb_clk = ~tb_clk;

    trace_capture #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W), .FILTER_X0(1'b1)
    ) dut (
        .clk(tb_clk), .reset(reset), .clr(clr), .cfg_en(cfg_en),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .drop_cnt(drop_cnt), .overflow(overflow), .conflict(conflict)
    );

    typedef struct {
        logic               clr;
        logic [2:0]         cfg;
        logic               rws;
        logic [4:0]         rnum;
        logic [31:0]        rdat;
        logic               w, r;
        logic [8:0]         a;
        logic [31:0]        wdat, mdat;
        logic               rdy;
        logic               ev;
        int                 lvl, drp;
        logic               ovf, cnf;
        logic [ENTRY_W-1:0] head;
    } vec_t;

    vec_t vt[$];

    // Reference model state
    logic [ENTRY_W-1:0] mq[$];
    int m_ts, m_drop;
    bit m_ovf, m_cnf;

    function automatic logic [ENTRY_W-1:0] ent(input int t, input int idx, input logic [31:0] d, input int s);
        return {2'(t), 9'(idx), d, 8'(s)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic [2:0] cf, input logic rws, input logic [4:0] rn,
                         input logic [31:0] rdt, input logic w, input logic r, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] md, input logic rdy);
        clr = c; cfg_en = cf; reg_write_sig = rws; reg_num = rn; reg_data = rdt;
        wr = w; rd = r; addr = a; wr_data = wd; rd_data = md; out_ready = rdy;
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // Model: the k-th qualifying event of a cycle is kept iff k < free slots at cycle start.
    task automatic model(input logic c, input logic [2:0] cf, input logic rws, input logic [4:0] rn,
                         input logic [31:0] rdt, input logic w, input logic r, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] md, input logic rdy);
        logic [ENTRY_W-1:0] cand[$];
        int free, nd;
        free = DEPTH - mq.size();
        if (c) begin
            mq.delete(); m_ts = 0; m_drop = 0; m_ovf = 0; m_cnf = 0;
        end else begin
            if (rws && cf[0] && rn != 0) cand.push_back(ent(1, int'(rn), rdt, m_ts));
            if (w && !r && cf[1]) cand.push_back(ent(2, int'(a), wd, m_ts));
            if (r && !w && cf[2]) cand.push_back(ent(3, int'(a), md, m_ts));
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            nd = 0;
            foreach (cand[i]) begin
                if (i < free) mq.push_back(cand[i]);
                else nd++;
            end
            m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
            if (nd > 0) m_ovf = 1;
            if (w && r) m_cnf = 1;
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
    endtask

    task automatic cmp_model();
        chk("rnd_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("rnd_level", 64'(level), 64'(mq.size()));
        chk("rnd_drop", 64'(drop_cnt), 64'(m_drop));
        chk("rnd_ovf", 64'(overflow), 64'(m_ovf));
        chk("rnd_conflict", 64'(conflict), 64'(m_cnf));
        if (mq.size() > 0) chk("rnd_head", 64'(out_data), 64'(mq[0]));
    endtask

    initial begin
        drive(0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_conflict", 64'(conflict), 64'd0);
        reset = 1'b0;

        // clr cfg rws rn rdat w r a wdat mdat rdy | ev lvl drp ovf cnf head
        vt.push_back('{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, '0});
        vt.push_back('{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, '0});
        vt.push_back('{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, '0});
        vt.push_back('{0, 7, 1, 5, 'h2A, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, ent(1, 5, 'h2A, 3)});
        vt.push_back('{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, '0});
        vt.push_back('{0, 7, 1, 7, 'hFFFFFFFF, 1, 0, 'h100, 9, 0, 0,   1, 2, 0, 0, 0, ent(1, 7, 'hFFFFFFFF, 5)});
        vt.push_back('{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, ent(2, 'h100, 9, 5)});
        vt.push_back('{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, '0});
        vt.push_back('{0, 5, 1, 0, 'h55, 1, 0, 3, 1, 0, 1,   0, 0, 0, 0, 0, '0});
        vt.push_back('{0, 0, 0, 0, 0, 1, 1, 6, 2, 3, 1,   0, 0, 0, 0, 1, '0});
        vt.push_back('{0, 7, 1, 1, 1, 0, 1, 2, 0, 'hB, 0,   1, 2, 0, 0, 1, ent(1, 1, 1, 10)});
        vt.push_back('{0, 7, 1, 2, 2, 0, 0, 0, 0, 0, 0,   1, 3, 0, 0, 1, ent(1, 1, 1, 10)});
        vt.push_back('{0, 7, 1, 3, 3, 0, 1, 4, 0, 'hC, 0,   1, 4, 1, 1, 1, ent(1, 1, 1, 10)});
        vt.push_back('{0, 7, 1, 4, 4, 1, 0, 5, 'hD, 0, 0,   1, 4, 3, 1, 1, ent(1, 1, 1, 10)});
        vt.push_back('{0, 7, 1, 6, 6, 0, 0, 0, 0, 0, 1,   1, 3, 4, 1, 1, ent(3, 2, 'hB, 10)});
        vt.push_back('{1, 7, 1, 9, 9, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, '0});
        vt.push_back('{0, 7, 1, 10, 'h77, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, ent(1, 10, 'h77, 0)});
        vt.push_back('{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, '0});

        foreach (vt[i]) begin
            drive(vt[i].clr, vt[i].cfg, vt[i].rws, vt[i].rnum, vt[i].rdat, vt[i].w, vt[i].r,
                  vt[i].a, vt[i].wdat, vt[i].mdat, vt[i].rdy);
            step();
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_level", i), 64'(level), 64'(vt[i].lvl));
            chk($sformatf("vec%0d_drop", i), 64'(drop_cnt), 64'(vt[i].drp));
            chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vt[i].ovf));
            chk($sformatf("vec%0d_conflict", i), 64'(conflict), 64'(vt[i].cnf));
            if (vt[i].ev) chk($sformatf("vec%0d_head", i), 64'(out_data), 64'(vt[i].head));
        end

        // Fill and drain three times so both pointers wrap repeatedly.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                drive(0, 3'b111, 1, 5'(k + 1), 32'(r * DEPTH + k), 0, 0, 0, 0, 0, 0);
                step();
            end
            chk("wrap_full", 64'(level), 64'(DEPTH));
            for (int k = 0; k < DEPTH; k++) begin
                chk("wrap_order", {31'd0, out_valid, out_data[TS_W +: DATA_W]}, {31'd0, 1'b1, 32'(r * DEPTH + k)});
                drive(0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 1);
                step();
            end
            chk("wrap_empty", 64'(level), 64'd0);
        end

        // Asynchronous reset with entries held must empty the FIFO immediately.
        for (int k = 0; k < 2; k++) begin
            drive(0, 3'b111, 1, 5'(k + 3), 32'(k), 0, 0, 0, 0, 0, 0);
            step();
        end
        chk("pre_reset_level", 64'(level), 64'd2);
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_level", 64'(level), 64'd0);
        drive(0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        mq.delete(); m_ts = 0; m_drop = 0; m_ovf = 0; m_cnf = 0;

        for (int n = 0; n < 3000; n++) begin
            logic c, rws, w, r, rdy;
            logic [2:0] cf;
            logic [4:0] rn;
            logic [8:0] a;
            logic [31:0] rdt, wd, md;
            c   = ($urandom_range(99) == 0);
            cf  = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'b111;
            rws = 1'($urandom_range(1));
            rn  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            w   = ($urandom_range(2) == 0);
            r   = ($urandom_range(2) == 0);
            a   = 9'($urandom);
            rdt = $urandom; wd = $urandom; md = $urandom;
            rdy = ($urandom_range(9) < 4);
            drive(c, cf, rws, rn, rdt, w, r, a, wd, md, rdy);
            model(c, cf, rws, rn, rdt, w, r, a, wd, md, rdy);
            step();
            cmp_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
